// File: rtl/mf_coeff_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : mf_coeff_receiver
//  Description : Captures a streamed set of LENGTH complex matched-filter
//                coefficients into two internal arrays after an enable/latency
//                handshake with the coefficient source, then serves 1-cycle
//                latency random-access reads once the load has been confirmed.
//                Build macro MF_COEFF_CONJ_REV_EN: store the taps
//                time-reversed and conjugated (conj(s(-t))), with saturating
//                negation of the imaginary part.
//  Revision    : 1.0  initial release
// ============================================================================
module mf_coeff_receiver #(
    parameter int LENGTH     = 10000,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    output logic                         coeffEnable,
    input  logic signed [DATA_WIDTH-1:0] coeffInRe,
    input  logic signed [DATA_WIDTH-1:0] coeffInIm,
    input  logic                         coeffSetFlag,
    input  logic                         readEn,
    input  logic        [ADDR_WIDTH-1:0] readAddr,
    output logic signed [DATA_WIDTH-1:0] readRe,
    output logic signed [DATA_WIDTH-1:0] readIm,
    output logic                         readValid,
    output logic                         coeffLoaded,
    output logic                         loadError
);

    // Index width of the coefficient arrays (at least one bit).
    localparam int c_idx_w = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    // Last word index, used both for end-of-capture and address reversal.
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(LENGTH - 1);
    // LENGTH extended by one bit so readAddr can be range-checked even when
    // LENGTH equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] c_length_ext = (ADDR_WIDTH + 1)'(LENGTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ALIGN   = 3'd1,
        S_CAPTURE = 3'd2,
        S_CHECK   = 3'd3,
        S_LOADED  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 step_q, step_d;          // 2-cycle phase in ALIGN / CHECK
    logic [c_idx_w-1:0]   wr_cnt_q, wr_cnt_d;
    logic                 coeff_enable_q, coeff_enable_d;
    logic                 coeff_loaded_q, coeff_loaded_d;
    logic                 load_error_q, load_error_d;
    logic                 read_valid_q, read_valid_d;
    logic signed [DATA_WIDTH-1:0] read_re_q, read_re_d;
    logic signed [DATA_WIDTH-1:0] read_im_q, read_im_d;

    logic                          wr_en;
    logic [c_idx_w-1:0]            wr_addr;
    logic signed [DATA_WIDTH-1:0]  wr_re;
    logic signed [DATA_WIDTH-1:0]  wr_im;
    logic                          rd_hit;
    logic [c_idx_w-1:0]            rd_idx;

    logic signed [DATA_WIDTH-1:0] mem_re [LENGTH];
    logic signed [DATA_WIDTH-1:0] mem_im [LENGTH];

`ifdef MF_COEFF_CONJ_REV_EN
    localparam logic signed [DATA_WIDTH-1:0] c_min_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] c_max_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // Time-reverse the address and conjugate, saturating the one value whose
    // negation is not representable.
    always_comb begin
        wr_addr = c_last_idx - wr_cnt_q;
        wr_re   = coeffInRe;
        wr_im   = (coeffInIm == c_min_val) ? c_max_val : -coeffInIm;
    end
`else
    // Store each word at its arrival index exactly as received.
    always_comb begin
        wr_addr = wr_cnt_q;
        wr_re   = coeffInRe;
        wr_im   = coeffInIm;
    end
`endif

    // Load sequencer: next state, counters and status flags.
    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        wr_cnt_d       = wr_cnt_q;
        coeff_enable_d = coeff_enable_q;
        coeff_loaded_d = coeff_loaded_q;
        load_error_d   = load_error_q;
        wr_en          = 1'b0;
        case (state_q)
            S_IDLE, S_LOADED, S_ERROR: begin
                if (start) begin
                    state_d        = S_ALIGN;
                    step_d         = 1'b0;
                    wr_cnt_d       = '0;
                    coeff_enable_d = 1'b1;
                    coeff_loaded_d = 1'b0;
                    load_error_d   = 1'b0;
                end
            end
            S_ALIGN: begin
                // Two cycles covering the source's enable-to-data latency.
                if (step_q) begin
                    state_d = S_CAPTURE;
                    step_d  = 1'b0;
                end else begin
                    step_d  = 1'b1;
                end
            end
            S_CAPTURE: begin
                wr_en = 1'b1;
                if (wr_cnt_q == c_last_idx) begin
                    state_d = S_CHECK;
                    step_d  = 1'b0;
                end else begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (coeffSetFlag) begin
                    state_d        = S_LOADED;
                    coeff_loaded_d = 1'b1;
                    coeff_enable_d = 1'b0;
                end else if (step_q) begin
                    state_d        = S_ERROR;
                    load_error_d   = 1'b1;
                    coeff_enable_d = 1'b0;
                end else begin
                    step_d = 1'b1;
                end
            end
            default: begin
                state_d        = S_IDLE;
                step_d         = 1'b0;
                wr_cnt_d       = '0;
                coeff_enable_d = 1'b0;
                coeff_loaded_d = 1'b0;
                load_error_d   = 1'b0;
            end
        endcase
    end

    // Read port: only a fully confirmed table is readable, and a read that
    // collides with a reload request is dropped.
    always_comb begin
        rd_idx       = readAddr[c_idx_w-1:0];
        rd_hit       = readEn && (state_q == S_LOADED) && !start &&
                       ({1'b0, readAddr} < c_length_ext);
        read_valid_d = rd_hit;
        read_re_d    = '0;
        read_im_d    = '0;
        if (rd_hit) begin
            read_re_d = mem_re[rd_idx];
            read_im_d = mem_im[rd_idx];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            step_q         <= 1'b0;
            wr_cnt_q       <= '0;
            coeff_enable_q <= 1'b0;
            coeff_loaded_q <= 1'b0;
            load_error_q   <= 1'b0;
            read_valid_q   <= 1'b0;
            read_re_q      <= '0;
            read_im_q      <= '0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            wr_cnt_q       <= wr_cnt_d;
            coeff_enable_q <= coeff_enable_d;
            coeff_loaded_q <= coeff_loaded_d;
            load_error_q   <= load_error_d;
            read_valid_q   <= read_valid_d;
            read_re_q      <= read_re_d;
            read_im_q      <= read_im_d;
        end
    end

    // Coefficient storage; writes are suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            mem_re[wr_addr] <= wr_re;
            mem_im[wr_addr] <= wr_im;
        end
    end

    assign coeffEnable = coeff_enable_q;
    assign coeffLoaded = coeff_loaded_q;
    assign loadError   = load_error_q;
    assign readValid   = read_valid_q;
    assign readRe      = read_re_q;
    assign readIm      = read_im_q;

endmodule
`default_nettype wire

// File: tb/tb_mf_coeff_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mf_coeff_receiver
//  Description : Self-checking bench for mf_coeff_receiver (LENGTH=4,
//                DATA_WIDTH=16). Directed read table, hand-written load /
//                reset sequences and randomized loads checked against a
//                reference model of the stored coefficient table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mf_coeff_receiver;

    localparam int LEN = 4;
    localparam int DW  = 16;
    localparam int AW  = 20;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic                 coeffSetFlag = 1'b0;
    logic                 readEn = 1'b0;
    logic signed [DW-1:0] coeffInRe = '0;
    logic signed [DW-1:0] coeffInIm = '0;
    logic [AW-1:0]        readAddr = '0;
    logic                 coeffEnable, readValid, coeffLoaded, loadError;
    logic signed [DW-1:0] readRe, readIm;

    mf_coeff_receiver #(.LENGTH(LEN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .coeffEnable (coeffEnable),
        .coeffInRe   (coeffInRe),
        .coeffInIm   (coeffInIm),
        .coeffSetFlag(coeffSetFlag),
        .readEn      (readEn),
        .readAddr    (readAddr),
        .readRe      (readRe),
        .readIm      (readIm),
        .readValid   (readValid),
        .coeffLoaded (coeffLoaded),
        .loadError   (loadError)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: source words and the table a reader should observe.
    int src_re [LEN];
    int src_im [LEN];
    int m_re   [LEN];
    int m_im   [LEN];
    bit m_loaded = 1'b0;

    typedef struct {
        bit en;
        int addr;
        bit valid;
        int re;
        int im;
    } rd_vec_t;

    rd_vec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int neg_sat(input int v);
        if (v == -(1 << (DW - 1))) return (1 << (DW - 1)) - 1;
        return -v;
    endfunction

    // A confirmed load makes the source words visible in the table.
    task automatic commit_model();
        for (int k = 0; k < LEN; k++) begin
`ifdef MF_COEFF_CONJ_REV_EN
            m_re[LEN-1-k] = src_re[k];
            m_im[LEN-1-k] = neg_sat(src_im[k]);
`else
            m_re[k] = src_re[k];
            m_im[k] = src_im[k];
`endif
        end
        m_loaded = 1'b1;
    endtask

    task automatic chk_status(input string tag, input int en, input int ld, input int er);
        chk({tag, " coeffEnable"}, coeffEnable, en);
        chk({tag, " coeffLoaded"}, coeffLoaded, ld);
        chk({tag, " loadError"},   loadError,   er);
    endtask

    // Issue one read, advance one edge, compare against the model.
    task automatic do_read(input string tag, input bit en, input int addr);
        bit hit;
        hit = en && m_loaded && (addr < LEN);
        readEn   = en;
        readAddr = AW'(addr);
        tick();
        readEn = 1'b0;
        chk({tag, " readValid"}, readValid, hit);
        chk({tag, " readRe"}, readRe, hit ? m_re[addr] : 0);
        chk({tag, " readIm"}, readIm, hit ? m_im[addr] : 0);
    endtask

    // Full load handshake. mode 0: flag seen at first check edge,
    // 1: flag seen at second check edge, 2: flag never -> error.
    task automatic do_load(input bit skip_start, input bit mid_start, input int mode);
        m_loaded = 1'b0;
        if (!skip_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk_status("load E0", 1, 0, 0);
        end
        tick();
        tick();
        chk_status("load align", 1, 0, 0);
        for (int k = 0; k < LEN; k++) begin
            coeffInRe    = DW'(src_re[k]);
            coeffInIm    = DW'(src_im[k]);
            start        = mid_start && (k == 1);
            coeffSetFlag = (mode == 0) && (k == LEN - 1);
            tick();
        end
        start = 1'b0;
        chk_status("load last word", 1, 0, 0);
        coeffSetFlag = (mode == 0);
        tick();
        if (mode == 0) begin
            chk_status("load check1", 0, 1, 0);
            commit_model();
        end else begin
            chk_status("load check1 wait", 1, 0, 0);
            coeffSetFlag = (mode == 1);
            tick();
            if (mode == 1) begin
                chk_status("load check2", 0, 1, 0);
                commit_model();
            end else begin
                chk_status("load error", 0, 0, 1);
            end
        end
        coeffSetFlag = 1'b0;
        coeffInRe    = '0;
        coeffInIm    = '0;
    endtask

    task automatic set_directed_stream();
        for (int k = 0; k < LEN; k++) begin
            src_re[k] = k + 1;
            src_im[k] = -(k + 1);
        end
    endtask

    initial begin
        // Directed read table for stream (1,-1),(2,-2),(3,-3),(4,-4).
`ifdef MF_COEFF_CONJ_REV_EN
        tbl[0] = '{1'b1, 2, 1'b1, 2, 2};
        tbl[1] = '{1'b1, 0, 1'b1, 4, 4};
        tbl[2] = '{1'b1, 3, 1'b1, 1, 1};
        tbl[3] = '{1'b1, 1, 1'b1, 3, 3};
`else
        tbl[0] = '{1'b1, 2, 1'b1, 3, -3};
        tbl[1] = '{1'b1, 0, 1'b1, 1, -1};
        tbl[2] = '{1'b1, 3, 1'b1, 4, -4};
        tbl[3] = '{1'b1, 1, 1'b1, 2, -2};
`endif
        tbl[4] = '{1'b1, 4, 1'b0, 0, 0};
        tbl[5] = '{1'b0, 1, 1'b0, 0, 0};
        tbl[6] = '{1'b1, 7, 1'b0, 0, 0};
        tbl[7] = '{1'b1, 1048575, 1'b0, 0, 0};

        // Reset state.
        reset = 1'b0;
        tick();
        tick();
        chk_status("reset", 0, 0, 0);
        chk("reset readValid", readValid, 0);
        chk("reset readRe", readRe, 0);
        chk("reset readIm", readIm, 0);
        reset = 1'b1;
        tick();
        chk("idle coeffEnable", coeffEnable, 0);
        do_read("idle read", 1'b1, 0);

        // Directed load and table of reads.
        set_directed_stream();
        do_load(1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            readEn   = tbl[i].en;
            readAddr = AW'(tbl[i].addr);
            tick();
            readEn = 1'b0;
            chk($sformatf("tbl[%0d] readValid", i), readValid, tbl[i].valid);
            chk($sformatf("tbl[%0d] readRe", i), readRe, tbl[i].re);
            chk($sformatf("tbl[%0d] readIm", i), readIm, tbl[i].im);
        end

        // Reload requested with a colliding read: read dropped, reload runs.
        readEn   = 1'b1;
        readAddr = '0;
        start    = 1'b1;
        tick();
        start  = 1'b0;
        readEn = 1'b0;
        chk("reload readValid", readValid, 0);
        chk("reload readRe", readRe, 0);
        chk_status("reload E0", 1, 0, 0);
        m_loaded = 1'b0;
        src_re[0] = 5;
        src_im[0] = -32768;
        do_load(1'b1, 1'b1, 1);
        for (int a = 0; a < LEN; a++) do_read("reload table", 1'b1, a);

        // Missing source-done flag leads to a sticky error.
        set_directed_stream();
        do_load(1'b0, 1'b0, 2);
        do_read("error read", 1'b1, 0);
        tick();
        chk_status("error sticky", 0, 0, 1);

        // Reset in the middle of capture abandons the load.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            coeffInRe = DW'(k + 10);
            tick();
        end
        coeffInRe = DW'(12);
        reset     = 1'b0;
        m_loaded  = 1'b0;
        tick();
        chk_status("mid reset", 0, 0, 0);
        chk("mid reset readValid", readValid, 0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post reset coeffEnable", coeffEnable, 0);
        end
        do_read("post reset read", 1'b1, 1);

        // Randomized loads and reads.
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < LEN; k++) begin
                src_re[k] = int'($urandom_range(0, 65535)) - 32768;
                src_im[k] = ($urandom_range(0, 7) == 0) ? -32768
                          : int'($urandom_range(0, 65535)) - 32768;
            end
            do_load(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            for (int r = 0; r < 8; r++)
                do_read("rand read", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 5)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
